// File: rtl/meter_peak_hold.sv
// Per-channel peak-magnitude meter with a sticky clip flag. It is fed by the DSP aux_out
// stream, and memif reads it with optional clear-on-read.
module meter_peak_hold #(
   parameter int                    DATA_WIDTH = 24,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] CLIP_LEVEL = 24'h7FF000
) (
   input  logic                  dsp_clk,
   input  logic                  reset_n,
   input  logic                  in_en,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_clear,
   output logic                  rd_busy,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  init_busy
);
   localparam int MAG_WIDTH = DATA_WIDTH - 1;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {OP_NONE, OP_UPD, OP_READ} op_t;

   logic [ADDR_WIDTH-1:0] sweep_addr;

   logic                  pend;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic                  pend_clear;

   logic [DATA_WIDTH-1:0] in_abs;
   logic [MAG_WIDTH-1:0]  in_mag;
   logic                  in_clip;

   op_t                   sel_op;
   logic [ADDR_WIDTH-1:0] sel_addr;

   op_t                   a_op;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [MAG_WIDTH-1:0]  a_mag;
   logic                  a_clip;
   logic                  a_clear;

   op_t                   b_op;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [MAG_WIDTH-1:0]  b_mag;
   logic                  b_clip;
   logic                  b_clear;

   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;

   logic [DATA_WIDTH-1:0] ram [DEPTH];
   logic [DATA_WIDTH-1:0] ram_q;

   logic [DATA_WIDTH-1:0] old_entry;
   logic [MAG_WIDTH-1:0]  old_mag;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_wr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   // Post-reset clearing sweep; the table holds garbage until it completes.
   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         init_busy  <= 1'b1;
         sweep_addr <= '0;
      end else if (init_busy) begin
         sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
         if (sweep_addr == '1) init_busy <= 1'b0;
      end
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_busy    <= 1'b0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         pend_clear <= 1'b0;
      end else if (rd_req && !rd_busy) begin
         rd_busy    <= 1'b1;
         pend       <= 1'b1;
         pend_addr  <= rd_addr;
         pend_clear <= rd_clear;
      end else begin
         if (sel_op == OP_READ) pend <= 1'b0;
         if (b_op == OP_READ) rd_busy <= 1'b0;
      end
   end

   // The most-negative sample negates to itself, so it saturates to full scale.
   always_comb begin
      in_abs  = in_data[DATA_WIDTH-1] ? (~in_data + DATA_WIDTH'(1)) : in_data;
      in_mag  = in_abs[DATA_WIDTH-1] ? '1 : in_abs[MAG_WIDTH-1:0];
      in_clip = ({1'b0, in_mag} >= CLIP_LEVEL);
   end

   // A pending read yields to in_en; samples are never stalled.
   always_comb begin
      sel_op   = OP_NONE;
      sel_addr = in_addr;
      if (!init_busy) begin
         if (in_en) begin
            sel_op = OP_UPD;
         end else if (pend) begin
            sel_op   = OP_READ;
            sel_addr = pend_addr;
         end
      end
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         a_op     <= OP_NONE;
         a_addr   <= '0;
         a_mag    <= '0;
         a_clip   <= 1'b0;
         a_clear  <= 1'b0;
         b_op     <= OP_NONE;
         b_addr   <= '0;
         b_mag    <= '0;
         b_clip   <= 1'b0;
         b_clear  <= 1'b0;
         fwd_hit  <= 1'b0;
         fwd_data <= '0;
      end else begin
         a_op     <= sel_op;
         a_addr   <= sel_addr;
         a_mag    <= in_mag;
         a_clip   <= in_clip;
         a_clear  <= (sel_op == OP_READ) && pend_clear;
         b_op     <= a_op;
         b_addr   <= a_addr;
         b_mag    <= a_mag;
         b_clip   <= a_clip;
         b_clear  <= a_clear;
         // RAM q read at this edge would miss the write landing on the same edge.
         fwd_hit  <= b_wr && (a_op != OP_NONE) && (b_addr == a_addr);
         fwd_data <= b_wdata;
      end
   end

   always_ff @(posedge dsp_clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      ram_q <= ram[a_addr];
   end

   always_comb begin
      old_entry = fwd_hit ? fwd_data : ram_q;
      old_mag   = old_entry[MAG_WIDTH-1:0];
      b_wr      = (b_op == OP_UPD) || ((b_op == OP_READ) && b_clear);
      b_wdata   = '0;
      if (b_op == OP_UPD)
         b_wdata = {old_entry[DATA_WIDTH-1] | b_clip, (old_mag > b_mag) ? old_mag : b_mag};
   end

   always_comb begin
      wr_en   = init_busy | b_wr;
      wr_addr = init_busy ? sweep_addr : b_addr;
      wr_data = init_busy ? '0 : b_wdata;
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= (b_op == OP_READ);
         if (b_op == OP_READ) rd_data <= old_entry;
      end
   end

endmodule
